// File: rtl/uart_rx_os.sv
// ---------------------------------------------------------------------------
// uart_rx_os -- oversampling UART receiver (8N1 by default).
//
// Samples the rx line on every clken tick. Each bit is decided by a 3-sample
// majority vote around mid-bit. Single-tick start glitches are rejected.
// A bad stop bit raises frame_err, and a byte dropped while rdy is still
// set raises overrun. Received bytes go to the bus side through rdy/rdy_clr.
//
// Parameters:
//   DATA_BITS  - data bits per frame, LSB first (5..9)
//   OVERSAMPLE - clken ticks per bit period (even, >= 8)
//
// Ports:
//   clk_50m   in   system clock
//   reset     in   asynchronous, active-high reset
//   clken     in   single-cycle oversample tick
//   rx        in   asynchronous serial input, idle high
//   rdy_clr   in   one-cycle pulse: consumer has taken dout
//   dout      out  last good received byte
//   rdy       out  dout holds an unread byte
//   frame_err out  sticky: a frame arrived with a bad stop bit
//   overrun   out  sticky: a byte was dropped because rdy was still set
//   busy      out  receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk_50m,
    input  logic                 reset,
    input  logic                 clken,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rdy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int M     = OVERSAMPLE / 2;
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] C_VOTE0    = CNT_W'(M - 1);
    localparam logic [CNT_W-1:0] C_VOTE1    = CNT_W'(M);
    localparam logic [CNT_W-1:0] C_VOTE2    = CNT_W'(M + 1);
    localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] C_LAST_BIT = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_vote;
    logic [DATA_BITS-1:0] r_dout;
    logic                 r_rdy;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic w_maj_live;
    logic w_maj_held;
    logic w_shift_en;
    logic w_good_stop;
    logic w_bad_stop;
    logic w_cnt_clr;

    // The start and stop bits are decided on the third vote tick itself, so
    // the live synchronized sample stands in for the third vote. Data bits
    // are committed at the end of the bit from the three stored votes.
    assign w_maj_live = (r_vote[0] & r_vote[1]) | (r_vote[0] & r_rx_s) | (r_vote[1] & r_rx_s);
    assign w_maj_held = (r_vote[0] & r_vote[1]) | (r_vote[0] & r_vote[2]) | (r_vote[1] & r_vote[2]);

    // NOTE: the synchronizer resets to 1 (idle line) so that reset release
    // cannot look like a start edge.
    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let r_rx_s take the old
            // r_rx_meta, which gives two real flops rather than one.
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_next = r_state;
        w_shift_en   = 1'b0;
        w_good_stop  = 1'b0;
        w_bad_stop   = 1'b0;
        if (clken) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) w_state_next = S_START;
                end
                S_START: begin
                    if (r_cnt == C_VOTE2 && w_maj_live) w_state_next = S_IDLE;
                    else if (r_cnt == C_LAST)           w_state_next = S_DATA;
                end
                S_DATA: begin
                    if (r_cnt == C_LAST) begin
                        w_shift_en = 1'b1;
                        if (r_bit_idx == C_LAST_BIT) w_state_next = S_STOP;
                    end
                end
                S_STOP: begin
                    // Early decision leaves half a bit to catch the next start.
                    if (r_cnt == C_VOTE2) begin
                        if (w_maj_live) begin
                            w_good_stop  = 1'b1;
                            w_state_next = S_IDLE;
                        end else begin
                            w_bad_stop   = 1'b1;
                            w_state_next = S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // A line held low reports one framing error only.
                    if (r_rx_s) w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // The counter restarts on every state change and at the end of each bit.
    assign w_cnt_clr = (r_state == S_IDLE) || (r_state == S_BREAK) ||
                       (w_state_next != r_state) || (r_cnt == C_LAST);

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_vote    <= 3'b111;
        end else if (clken) begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + 1'b1;

            if (r_state == S_START || r_state == S_DATA || r_state == S_STOP) begin
                if (r_cnt == C_VOTE0) r_vote[0] <= r_rx_s;
                if (r_cnt == C_VOTE1) r_vote[1] <= r_rx_s;
                if (r_cnt == C_VOTE2) r_vote[2] <= r_rx_s;
            end

            if (r_state == S_START) begin
                r_bit_idx <= '0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 1'b1;
                r_shift   <= {w_maj_held, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    // rdy_clr is applied first, so a byte finishing in the same cycle sees
    // rdy as already cleared and the clear wins over new sticky flags.
    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            r_dout      <= '0;
            r_rdy       <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (rdy_clr) begin
                r_rdy       <= 1'b0;
                r_frame_err <= 1'b0;
                r_overrun   <= 1'b0;
            end
            if (w_good_stop) begin
                if (!r_rdy || rdy_clr) begin
                    r_dout <= r_shift;
                    r_rdy  <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
            if (w_bad_stop && !rdy_clr) r_frame_err <= 1'b1;
        end
    end

    assign dout      = r_dout;
    assign rdy       = r_rdy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);

endmodule
